// File: rtl/cm_pkg.sv
// Shared definitions for the cm_merge two-input four-phase merge.
package cm_pkg;

  localparam int unsigned CM_W_DEFAULT = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    REL
  } cm_state_e;

endpackage

// File: rtl/hs_sync.sv
// Two-flop synchronizer for a single handshake line; both flops reset to 0.
module hs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cm_merge.sv
// Round-robin merge of two four-phase channels onto one downstream channel.
// Define CM_MERGE_SYNC_EN to synchronize Send_in_a/b and Ack_in into CLK.
module cm_merge
  import cm_pkg::*;
#(
  parameter int unsigned W = CM_W_DEFAULT
) (
  input  logic         CLK,
  input  logic         MR_N,
  input  logic         CM_Send_in_a,
  input  logic         CM_Send_in_b,
  input  logic [W-1:0] CM_Data_in_a,
  input  logic [W-1:0] CM_Data_in_b,
  output logic         CM_Ack_out_a,
  output logic         CM_Ack_out_b,
  output logic         CM_Send_out,
  output logic [W-1:0] CM_Data_out,
  output logic         CM_Src,
  input  logic         CM_Ack_in,
  output logic         CM_CP
);

  logic      send_a;
  logic      send_b;
  logic      ack_in;
  logic      elig_a;
  logic      elig_b;
  logic      grant;
  logic      grant_src;
  logic      clr_send;
  logic      last_src;
  cm_state_e state;
  cm_state_e state_nx;

`ifdef CM_MERGE_SYNC_EN
  hs_sync u_sync_send_a (.clk(CLK), .rst_n(MR_N), .d(CM_Send_in_a), .q(send_a));
  hs_sync u_sync_send_b (.clk(CLK), .rst_n(MR_N), .d(CM_Send_in_b), .q(send_b));
  hs_sync u_sync_ack_in (.clk(CLK), .rst_n(MR_N), .d(CM_Ack_in),    .q(ack_in));
`else
  assign send_a = CM_Send_in_a;
  assign send_b = CM_Send_in_b;
  assign ack_in = CM_Ack_in;
`endif

  assign elig_a = send_a & ~CM_Ack_out_a;
  assign elig_b = send_b & ~CM_Ack_out_b;

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_src = SRC_A;
    clr_send  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ack_in && (elig_a || elig_b)) begin
          grant = 1'b1;
          // b wins only when alone, or on contention when a was granted last
          grant_src = (elig_b && (!elig_a || last_src == SRC_A)) ? SRC_B : SRC_A;
          state_nx  = SEND;
        end
      end
      SEND: begin
        if (ack_in) begin
          clr_send = 1'b1;
          state_nx = REL;
        end
      end
      REL: begin
        if (!ack_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      CM_Send_out <= 1'b0;
      CM_Data_out <= '0;
      CM_Src      <= SRC_A;
      CM_CP       <= 1'b0;
      last_src    <= SRC_B;
    end else begin
      CM_CP <= grant;
      if (grant) begin
        CM_Data_out <= (grant_src == SRC_B) ? CM_Data_in_b : CM_Data_in_a;
        CM_Src      <= grant_src;
        last_src    <= grant_src;
        CM_Send_out <= 1'b1;
      end else if (clr_send) begin
        CM_Send_out <= 1'b0;
      end
    end
  end

  // Upstream acks follow their own requests, independent of the output FSM.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      CM_Ack_out_a <= 1'b0;
      CM_Ack_out_b <= 1'b0;
    end else begin
      if (!send_a)                           CM_Ack_out_a <= 1'b0;
      else if (grant && grant_src == SRC_A)  CM_Ack_out_a <= 1'b1;
      if (!send_b)                           CM_Ack_out_b <= 1'b0;
      else if (grant && grant_src == SRC_B)  CM_Ack_out_b <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cm_merge.sv
// Self-checking bench for cm_merge: directed scenarios plus a randomized token run.
module tb_cm_merge;

`ifdef CM_MERGE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       mr_n;
  logic       send_a, send_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b;
  logic       send_out;
  logic [7:0] data_out;
  logic       src;
  logic       ack_in;
  logic       cp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  cm_merge #(.W(8)) dut (
    .CLK(clk), .MR_N(mr_n),
    .CM_Send_in_a(send_a), .CM_Send_in_b(send_b),
    .CM_Data_in_a(data_a), .CM_Data_in_b(data_b),
    .CM_Ack_out_a(ack_a), .CM_Ack_out_b(ack_b),
    .CM_Send_out(send_out), .CM_Data_out(data_out), .CM_Src(src),
    .CM_Ack_in(ack_in), .CM_CP(cp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mr_n = 1'b0; send_a = 1'b0; send_b = 1'b0; ack_in = 1'b0;
    data_a = '0; data_b = '0;
    repeat (2) step();
    mr_n = 1'b1;
    step();
  endtask

  task automatic wait_send(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (send_out === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: Send_out never rose (got %b, want 1)", name, send_out);
    end
  endtask

  task automatic finish_out(input string name);
    bit ok = 1'b0;
    ack_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (send_out === 1'b0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: Send_out did not fall after Ack_in (got %b, want 0)", name, send_out);
    end
    ack_in = 1'b0;
    repeat (SL + 2) step();
  endtask

  task automatic release_ch(input bit ch, input string name);
    bit ok = 1'b0;
    if (ch) send_b = 1'b0; else send_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((ch ? ack_b : ack_a) === 1'b0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: Ack_out_%s stayed high after Send_in fell (want 0)", name, ch ? "b" : "a");
    end
  endtask

  task automatic test_reset();
    mr_n = 1'b0; send_a = 1'b1; data_a = 8'hE7; send_b = 1'b1; data_b = 8'h18; ack_in = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({ack_a, ack_b, send_out, cp, data_out, src} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack_a=%b ack_b=%b send=%b cp=%b data=%h src=%b, want all 0",
               ack_a, ack_b, send_out, cp, data_out, src);
    end
    send_a = 1'b0; send_b = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    send_a = 1'b1; data_a = 8'h5A;
    for (int i = 0; i < SL; i++) begin
      step();
      n_checks++;
      if (send_out !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early: Send_out=%b at edge %0d, want 0", send_out, i + 1);
      end
    end
    step();
    n_checks++;
    if ({send_out, data_out, src, ack_a, ack_b, cp} !== {1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: send=%b data=%h src=%b ack_a=%b ack_b=%b cp=%b, want 1 5a 0 1 0 1",
               send_out, data_out, src, ack_a, ack_b, cp);
    end
    step();
    n_checks++;
    if ({cp, send_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_cp_pulse: cp=%b send=%b, want cp=0 send=1", cp, send_out);
    end
    release_ch(1'b0, "single_release");
    finish_out("single_finish");
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    send_a = 1'b1; data_a = 8'h11; send_b = 1'b1; data_b = 8'h22;
    wait_send("contend1_wait", ok);
    n_checks++;
    if ({data_out, src, ack_a, ack_b} !== {8'h11, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL contend1: data=%h src=%b ack_a=%b ack_b=%b, want 11 0 1 0", data_out, src, ack_a, ack_b);
    end
    release_ch(1'b0, "contend1_release");
    finish_out("contend1_finish");
    wait_send("contend2_wait", ok);
    n_checks++;
    if ({data_out, src, ack_b} !== {8'h22, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL contend2: data=%h src=%b ack_b=%b, want 22 1 1", data_out, src, ack_b);
    end
    release_ch(1'b1, "contend2_release");
    finish_out("contend2_finish");
    send_a = 1'b1; data_a = 8'h33; send_b = 1'b1; data_b = 8'h44;
    wait_send("contend3_wait", ok);
    n_checks++;
    if ({data_out, src} !== {8'h33, 1'b0}) begin
      n_fail++;
      $display("FAIL contend3_rr: data=%h src=%b, want 33 0", data_out, src);
    end
    release_ch(1'b0, "contend3_release");
    finish_out("contend3_finish");
    wait_send("contend4_wait", ok);
    n_checks++;
    if ({data_out, src} !== {8'h44, 1'b1}) begin
      n_fail++;
      $display("FAIL contend4: data=%h src=%b, want 44 1", data_out, src);
    end
    release_ch(1'b1, "contend4_release");
    finish_out("contend4_finish");
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    send_a = 1'b1; data_a = 8'hA5;
    wait_send("stall_wait", ok);
    release_ch(1'b0, "stall_release_a");
    send_b = 1'b1; data_b = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({send_out, data_out, src, ack_b} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: send=%b data=%h src=%b ack_b=%b, want 1 a5 0 0",
                 i, send_out, data_out, src, ack_b);
      end
    end
    finish_out("stall_finish");
    wait_send("stall_b_wait", ok);
    n_checks++;
    if ({data_out, src, ack_b} !== {8'h3C, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_b_token: data=%h src=%b ack_b=%b, want 3c 1 1", data_out, src, ack_b);
    end
    release_ch(1'b1, "stall_release_b");
    finish_out("stall_b_finish");
  endtask

  task automatic test_ack_stuck();
    do_reset();
    ack_in = 1'b1;
    repeat (SL + 1) step();
    send_a = 1'b1; data_a = 8'h77;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if ({send_out, ack_a} !== 2'b00) begin
        n_fail++;
        $display("FAIL ack_stuck_hold cycle %0d: send=%b ack_a=%b, want 0 0", i, send_out, ack_a);
      end
    end
    ack_in = 1'b0;
    for (int i = 0; i < SL; i++) begin
      step();
      n_checks++;
      if (send_out !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_stuck_early: send=%b at edge %0d, want 0", send_out, i + 1);
      end
    end
    step();
    n_checks++;
    if ({send_out, data_out, src, ack_a} !== {1'b1, 8'h77, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ack_stuck_grant: send=%b data=%h src=%b ack_a=%b, want 1 77 0 1",
               send_out, data_out, src, ack_a);
    end
    release_ch(1'b0, "ack_stuck_release");
    finish_out("ack_stuck_finish");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    send_a = 1'b1; data_a = 8'h9C;
    wait_send("rstmid_wait", ok);
    #2 mr_n = 1'b0;
    #1;
    n_checks++;
    if ({ack_a, ack_b, send_out, cp, data_out, src} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: ack_a=%b ack_b=%b send=%b cp=%b data=%h src=%b, want all 0",
               ack_a, ack_b, send_out, cp, data_out, src);
    end
    step();
    mr_n = 1'b1;
    for (int i = 0; i < SL; i++) begin
      step();
      n_checks++;
      if (send_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_early: send=%b at edge %0d, want 0", send_out, i + 1);
      end
    end
    step();
    n_checks++;
    if ({send_out, data_out, src, ack_a, cp} !== {1'b1, 8'h9C, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_regrant: send=%b data=%h src=%b ack_a=%b cp=%b, want 1 9c 0 1 1",
               send_out, data_out, src, ack_a, cp);
    end
    release_ch(1'b0, "rstmid_release");
    finish_out("rstmid_finish");
  endtask

  task automatic producer(input bit ch, input int n);
    logic [7:0] d;
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 6)) step();
      d = 8'($urandom);
      if (ch) begin qb.push_back(d); data_b = d; send_b = 1'b1; end
      else    begin qa.push_back(d); data_a = d; send_a = 1'b1; end
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        step();
        if ((ch ? ack_b : ack_a) === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL rand_ack_timeout ch %0d token %0d: Ack_out never rose", ch, i);
        break;
      end
      release_ch(ch, "rand_release");
    end
  endtask

  task automatic consumer(input int total);
    bit ok;
    logic [7:0] exp;
    for (int t = 0; t < total; t++) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (send_out === 1'b1) begin ok = 1'b1; break; end
        step();
      end
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_token_timeout: token %0d never arrived", t);
        break;
      end
      n_checks++;
      if (cp !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_cp token %0d: cp=%b, want 1", t, cp);
      end
      n_checks++;
      if ((src ? qb.size() : qa.size()) == 0) begin
        n_fail++;
        $display("FAIL rand_spurious token %0d: src=%b data=%h with no pending request", t, src, data_out);
      end else begin
        exp = src ? qb.pop_front() : qa.pop_front();
        if (data_out !== exp) begin
          n_fail++;
          $display("FAIL rand_data token %0d src %b: got %h, want %h", t, src, data_out, exp);
        end
      end
      repeat ($urandom_range(0, 5)) step();
      ack_in = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (send_out === 1'b0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL rand_send_stuck token %0d: Send_out stayed 1", t);
      end
      repeat ($urandom_range(0, 4)) step();
      ack_in = 1'b0;
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    fork
      producer(1'b0, 40);
      producer(1'b1, 40);
      consumer(80);
    join
    n_checks++;
    if (qa.size() + qb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d a and %0d b tokens undelivered, want 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    mr_n = 1'b0; send_a = 1'b0; send_b = 1'b0; ack_in = 1'b0;
    data_a = '0; data_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_ack_stuck();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cm_merge.md
CM_MERGE -- requirements
Module: cm_merge

Interface
REQ-001 SHALL have parameter W, default 8, meaning the data payload width in bits.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port MR_N, input, 1 bit: master reset, asynchronous, active-low.
REQ-004 SHALL have ports CM_Send_in_a and CM_Send_in_b, input, 1 bit each: four-phase requests from upstream channels a and b (for example, the two CB branch outputs).
REQ-005 SHALL have ports CM_Data_in_a and CM_Data_in_b, input, W bits each: payloads, stable while the matching Send_in is high.
REQ-006 SHALL have ports CM_Ack_out_a and CM_Ack_out_b, output, 1 bit each: four-phase acknowledges to channels a and b.
REQ-007 SHALL have port CM_Send_out, output, 1 bit: four-phase request to the downstream stage.
REQ-008 SHALL have port CM_Data_out, output, W bits: the merged payload.
REQ-009 SHALL have port CM_Src, output, 1 bit: source of the current token; 0 = a, 1 = b.
REQ-010 SHALL have port CM_Ack_in, input, 1 bit: four-phase acknowledge from downstream.
REQ-011 SHALL have port CM_CP, output, 1 bit: one-cycle pulse on every token capture.

Function
REQ-012 SHALL treat channel x as eligible when Send_in_x=1 and Ack_out_x=0.
REQ-013 SHALL implement the output FSM states IDLE, SEND and REL.
REQ-014 SHALL, in IDLE with CM_Ack_in=0 and at least one eligible channel, on the next edge: capture the granted channel's data into CM_Data_out; set CM_Src; set Ack_out of the granted channel; set CM_Send_out=1; pulse CM_CP; go to SEND.
REQ-015 SHALL, in SEND, hold CM_Send_out=1 until CM_Ack_in=1 is sampled, then clear CM_Send_out and go to REL.
REQ-016 SHALL, in REL, go to IDLE on the edge where CM_Ack_in=0 is sampled.
REQ-017 SHALL clear each Ack_out_x on the edge where Send_in_x=0 is sampled, independently of the output FSM.
REQ-018 SHALL, when both channels are eligible in the same cycle, grant the channel opposite to the last one granted (round-robin); a single eligible channel is granted regardless of history.
REQ-019 SHALL grant at most one channel per token, and only in IDLE.
REQ-020 SHALL hold CM_Data_out and CM_Src stable from the CM_Send_out rise until the next capture.
REQ-021 SHALL have a latency of one CLK edge from Send_in_x sampled high (eligible, IDLE, Ack_in=0) to CM_Send_out=1.
REQ-022 SHALL leave an ungranted channel's request pending, with Ack_out low, and never drop it.
REQ-023 SHALL ignore CM_Ack_in=1 while in IDLE: no grant occurs until it returns to 0.

Reset
REQ-024 SHALL, while MR_N=0, force all of the following: state=IDLE; CM_Ack_out_a=0; CM_Ack_out_b=0; CM_Send_out=0; CM_CP=0; CM_Data_out=0; CM_Src=0; last-grant=b, so that a wins the first contention.
REQ-025 SHALL abandon any in-flight token on reset assertion mid-handshake and restart cleanly at IDLE after MR_N rises.

Configuration
REQ-026 SHALL, with macro CM_MERGE_SYNC_EN defined, pass CM_Send_in_a, CM_Send_in_b and CM_Ack_in through two-flop synchronizers (reset to 0) before all logic; this adds two cycles to every handshake latency.
REQ-027 SHALL, without CM_MERGE_SYNC_EN, use those inputs directly; they are then required to be synchronous to CLK.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/SEND/REL), the source encoding constants (SRC_A=0, SRC_B=1) and the default W in shared package cm_pkg.
REQ-029 SHALL implement the synchronizer as sub-module hs_sync (two flops, async active-low reset), instantiated once per synchronized input.

Verification
REQ-030 SHALL cover a single token: W=8, a sends 0x5A -> one edge later Send_out=1, Data_out=0x5A, Src=0, Ack_out_a=1, CP high for one cycle.
REQ-031 SHALL cover simultaneous requests after reset: a=0x11 and b=0x22 together -> first token 0x11 (Src=0), second token 0x22 (Src=1); then a repeated contention -> a wins.
REQ-032 SHALL cover downstream stall: Ack_in held low for 10 cycles -> Send_out stays 1, Data_out is unchanged, b's new request stays unacknowledged.
REQ-033 SHALL cover Ack_in stuck at 1 in IDLE: a requests -> no grant until Ack_in falls, then a grant on the next edge.
REQ-034 SHALL cover reset in SEND: MR_N pulsed low -> all outputs 0 immediately (asynchronously); after release, a pending a request is granted normally.
REQ-035 SHALL cover CM_MERGE_SYNC_EN defined: the single-token test of REQ-030 shows Send_out rising 3 edges after Send_in_a.
